hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Parametrised successor to the EX-stage operand forwarding unit.
// - Generates per-operand forwarding selects for NUM_SRC EX sources plus a store-data select.
// - Adds a multi-cycle load-use stall FSM (LD_LAT cycles) and a register scoreboard for
//   long-latency units (mul/div) that stalls EX until the pending result is produced.
// - Sits beside the EX stage; stall_o feeds the pipeline halt/bubble logic.
// PARAMETERS
// NUM_SRC   2   number of EX source operands checked (rs1..rsN)
// STORE_SRC 1   index of the source that carries store data
// LD_LAT    1   load-use stall length in cycles (1..15)
// NREG      32  architectural registers tracked by the scoreboard; x0 is never tracked
// PORTS
// clk            in   1          core clock, rising edge
// rst_n          in   1          asynchronous active-low reset
// ex_valid_i     in   1          EX holds a valid instruction
// ex_rs_i        in   NUM_SRC*5  source register indices, src k at [5k+4:5k]
// ex_alt_sel_i   in   NUM_SRC    1 = source k takes imm/PC (no hazard check)
// ex_store_i     in   1          EX instruction is a store
// mem_rd_i       in   5          MEM-stage destination
// mem_wen_i      in   1          MEM-stage writes rd
// mem_is_load_i  in   1          MEM-stage result comes from data memory
// wb_rd_i        in   5          WB-stage destination
// wb_wen_i       in   1          WB-stage writes rd
// lat_issue_i    in   1          long-latency op issued this cycle
// lat_issue_rd_i in   5          its destination
// lat_done_i     in   1          long-latency result written this cycle
// lat_done_rd_i  in   5          its destination
// flush_i        in   1          pipeline flush (branch/trap)
// fw_sel_o       out  NUM_SRC*2  per source: 00 regfile, 01 alt, 10 MEM, 11 WB
// st_fw_sel_o    out  2          store data: 00 regfile, 01 WB, 10 MEM
// stall_o        out  1          hold EX, bubble into MEM
// sb_busy_o      out  1          at least one scoreboard bit set
// BEHAVIOUR
// - match(X,k) = (X_rd==rs_k) && X_rd!=0 && X_wen. Source k is "used" when alt_sel[k]==0.
// - fw_sel[k] (comb): alt_sel -> 01; else match(MEM) && !load -> 10; else match(WB) -> 11;
//   else 00. MEM beats WB. A MEM load match selects 00 and raises load hazard.
// - st_fw_sel (only when ex_store_i): match(MEM,STORE_SRC) && !load -> 10;
//   else match(WB,STORE_SRC) -> 01; else 00. Checked even when alt_sel[STORE_SRC]=1.
//   A MEM load match on the store source raises load hazard.
// - load_haz = ex_valid_i && any used source (or store source) matches a MEM load.
// - Load FSM: IDLE, LDSTALL; 4-bit counter cnt.
//   IDLE: stall on load_haz (comb, same cycle). If load_haz && LD_LAT>1 -> LDSTALL, cnt=LD_LAT-2.
//   LDSTALL: stall_o=1 unconditionally; cnt==0 -> IDLE, else cnt--. Total stall = LD_LAT cycles.
//   LD_LAT=1: FSM never leaves IDLE.
// - Scoreboard pend[NREG-1:1]: set by lat_issue_i (rd!=0), cleared by lat_done_i.
//   Same rd set and clear in one cycle -> set wins. Issue to x0 ignored.
// - sb_haz = ex_valid_i && a used/store source has pend set and is not cleared this cycle
//   (lat_done_rd_i==rs -> no stall; data arrives via WB match).
// - stall_o = load_haz(IDLE) | (state==LDSTALL) | sb_haz. sb_busy_o = |pend (registered bits).
// - flush_i: FSM -> IDLE, cnt=0 next edge; scoreboard untouched (in-flight ops still write).
// - Reset (async, rst_n=0): state IDLE, cnt 0, pend all 0 -> stall_o 0, sb_busy_o 0.
//   fw_sel_o/st_fw_sel_o stay purely combinational of inputs.
// TESTING
// 1 mem_rd=5 wen !load, rs1=5, alt=0 -> fw_sel[0]=10, stall_o=0.
// 2 mem_rd=wb_rd=7 both wen, rs2=7 -> fw_sel[1]=10; rd=0 both -> 00; alt_sel[1]=1 -> 01.
// 3 LD_LAT=3, MEM load rd=9, rs2=9 -> stall_o high exactly 3 cycles, then 0; LD_LAT=1 -> 1 cycle.
// 4 issue rd=12, EX rs1=12 valid -> stall until lat_done rd=12 (low that cycle); same-cycle
//   issue+done rd=12 -> sb_busy_o stays 1.
// 5 store, alt_sel[1]=1, rs2=4, wb_rd=4 wen -> st_fw_sel=01, fw_sel[1]=01.
// 6 rst_n low mid-LDSTALL or mid-pending -> stall_o/sb_busy_o 0 immediately; flush mid-LDSTALL -> IDLE next.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// EX-stage hazard unit: operand/store forwarding selects, load-use stall FSM and a
// pending-write scoreboard for long-latency units.
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int STORE_SRC = 1,
    parameter int LD_LAT    = 1,
    parameter int NREG      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid_i,
    input  logic [NUM_SRC*5-1:0]   ex_rs_i,
    input  logic [NUM_SRC-1:0]     ex_alt_sel_i,
    input  logic                   ex_store_i,
    input  logic [4:0]             mem_rd_i,
    input  logic                   mem_wen_i,
    input  logic                   mem_is_load_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   wb_wen_i,
    input  logic                   lat_issue_i,
    input  logic [4:0]             lat_issue_rd_i,
    input  logic                   lat_done_i,
    input  logic [4:0]             lat_done_rd_i,
    input  logic                   flush_i,
    output logic [NUM_SRC*2-1:0]   fw_sel_o,
    output logic [1:0]             st_fw_sel_o,
    output logic                   stall_o,
    output logic                   sb_busy_o
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_LDSTALL = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = (LD_LAT > 1) ? 4'(LD_LAT - 2) : 4'd0;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [NREG-1:1] pend_q;
    logic [NREG-1:1] pend_d;
    logic [NREG-1:0] pend_full;
    logic            load_haz;
    logic            sb_haz;

    assign pend_full = {pend_q, 1'b0};

    always_comb begin
        logic [4:0] rs_k;
        logic       mem_hit;
        logic       wb_hit;
        logic       pend_hit;
        fw_sel_o    = '0;
        st_fw_sel_o = 2'b00;
        load_haz    = 1'b0;
        sb_haz      = 1'b0;
        rs_k        = '0;
        mem_hit     = 1'b0;
        wb_hit      = 1'b0;
        pend_hit    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rs_k     = ex_rs_i[5*k +: 5];
            mem_hit  = mem_wen_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_k);
            wb_hit   = wb_wen_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_k);
            pend_hit = (32'(rs_k) < NREG) && pend_full[rs_k]
                       && !(lat_done_i && (lat_done_rd_i == rs_k));
            // A MEM load match keeps the regfile select; the stall covers the gap.
            if (ex_alt_sel_i[k])
                fw_sel_o[2*k +: 2] = 2'b01;
            else if (mem_hit)
                fw_sel_o[2*k +: 2] = mem_is_load_i ? 2'b00 : 2'b10;
            else if (wb_hit)
                fw_sel_o[2*k +: 2] = 2'b11;
            if (!ex_alt_sel_i[k] || (ex_store_i && (k == STORE_SRC))) begin
                if (mem_hit && mem_is_load_i)
                    load_haz = 1'b1;
                if (pend_hit)
                    sb_haz = 1'b1;
            end
            if (ex_store_i && (k == STORE_SRC)) begin
                if (mem_hit)
                    st_fw_sel_o = mem_is_load_i ? 2'b00 : 2'b10;
                else if (wb_hit)
                    st_fw_sel_o = 2'b01;
            end
        end
        load_haz = load_haz && ex_valid_i;
        sb_haz   = sb_haz && ex_valid_i;
    end

    assign stall_o   = ((state_q == S_IDLE) && load_haz) || (state_q == S_LDSTALL) || sb_haz;
    assign sb_busy_o = |pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_haz && (LD_LAT > 1)) begin
                        state_q <= S_LDSTALL;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_LDSTALL: begin
                    if (cnt_q == 4'd0)
                        state_q <= S_IDLE;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Issue is applied after done so a same-register set/clear leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREG; r++) begin
            if (lat_done_i && (lat_done_rd_i == 5'(r)))
                pend_d[r] = 1'b0;
            if (lat_issue_i && (lat_issue_rd_i == 5'(r)))
                pend_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, directed multi-cycle sequences and a
// randomized run against a pending-set / remaining-stall-count model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [9:0] ex_rs;
    logic [1:0] alt;
    logic       store;
    logic [4:0] mem_rd;
    logic       mem_wen;
    logic       mem_ld;
    logic [4:0] wb_rd;
    logic       wb_wen;
    logic       issue;
    logic [4:0] issue_rd;
    logic       done;
    logic [4:0] done_rd;
    logic       flush;

    logic [3:0] fw3, fw1;
    logic [1:0] st3, st1;
    logic       stall3, stall1, busy3, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] mpend;
    int        rem3, rem1;

    hazard_scoreboard #(.NUM_SRC(2), .STORE_SRC(1), .LD_LAT(3), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_rs_i(ex_rs),
        .ex_alt_sel_i(alt), .ex_store_i(store), .mem_rd_i(mem_rd), .mem_wen_i(mem_wen),
        .mem_is_load_i(mem_ld), .wb_rd_i(wb_rd), .wb_wen_i(wb_wen), .lat_issue_i(issue),
        .lat_issue_rd_i(issue_rd), .lat_done_i(done), .lat_done_rd_i(done_rd),
        .flush_i(flush), .fw_sel_o(fw3), .st_fw_sel_o(st3), .stall_o(stall3),
        .sb_busy_o(busy3)
    );

    hazard_scoreboard #(.NUM_SRC(2), .STORE_SRC(1), .LD_LAT(1), .NREG(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_rs_i(ex_rs),
        .ex_alt_sel_i(alt), .ex_store_i(store), .mem_rd_i(mem_rd), .mem_wen_i(mem_wen),
        .mem_is_load_i(mem_ld), .wb_rd_i(wb_rd), .wb_wen_i(wb_wen), .lat_issue_i(issue),
        .lat_issue_rd_i(issue_rd), .lat_done_i(done), .lat_done_rd_i(done_rd),
        .flush_i(flush), .fw_sel_o(fw1), .st_fw_sel_o(st1), .stall_o(stall1),
        .sb_busy_o(busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       valid;
        logic       store;
        logic [1:0] alt;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] mem_rd;
        logic       mem_wen;
        logic       mem_ld;
        logic [4:0] wb_rd;
        logic       wb_wen;
        logic [3:0] exp_fw;
        logic [1:0] exp_st;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        ex_valid = 0; ex_rs = '0; alt = '0; store = 0;
        mem_rd = '0; mem_wen = 0; mem_ld = 0; wb_rd = '0; wb_wen = 0;
        issue = 0; issue_rd = '0; done = 0; done_rd = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        mpend = '0; rem3 = 0; rem1 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model ----
    function automatic logic [4:0] src_rs(int k);
        return ex_rs[5*k +: 5];
    endfunction

    function automatic bit hit(logic en, logic [4:0] rd, logic [4:0] rs);
        return en && rd != 0 && rd == rs;
    endfunction

    function automatic bit src_checked(int k);
        return !alt[k] || (store && k == 1);
    endfunction

    function automatic logic [1:0] m_fw(int k);
        if (alt[k]) return 2'b01;
        if (hit(mem_wen, mem_rd, src_rs(k))) return mem_ld ? 2'b00 : 2'b10;
        if (hit(wb_wen, wb_rd, src_rs(k))) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_st();
        if (!store) return 2'b00;
        if (hit(mem_wen, mem_rd, src_rs(1))) return mem_ld ? 2'b00 : 2'b10;
        if (hit(wb_wen, wb_rd, src_rs(1))) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_load_haz();
        bit h = 0;
        for (int k = 0; k < 2; k++)
            if (src_checked(k) && mem_ld && hit(mem_wen, mem_rd, src_rs(k))) h = 1;
        return ex_valid && h;
    endfunction

    function automatic bit m_sb_haz();
        bit h = 0;
        for (int k = 0; k < 2; k++)
            if (src_checked(k) && mpend[src_rs(k)] && !(done && done_rd == src_rs(k))) h = 1;
        return ex_valid && h;
    endfunction

    task automatic model_edge(input bit lh);
        if (flush) begin
            rem3 = 0; rem1 = 0;
        end else begin
            if (rem3 > 0) rem3--; else if (lh) rem3 = 3 - 1;
            if (rem1 > 0) rem1--; else if (lh) rem1 = 1 - 1;
        end
        if (done && done_rd != 0) mpend[done_rd] = 1'b0;
        if (issue && issue_rd != 0) mpend[issue_rd] = 1'b1;
    endtask

    initial begin
        //            v st alt rs1 rs2 mrd mw ml wrd ww  fw       st     stall
        vecs[0]  = '{1, 0, 2'b00, 5, 0, 5, 1, 0, 0, 0, 4'b0010, 2'b00, 0};
        vecs[1]  = '{1, 0, 2'b00, 0, 7, 7, 1, 0, 7, 1, 4'b1000, 2'b00, 0};
        vecs[2]  = '{1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1, 4'b0000, 2'b00, 0};
        vecs[3]  = '{1, 0, 2'b10, 0, 7, 7, 1, 0, 7, 1, 4'b0100, 2'b00, 0};
        vecs[4]  = '{1, 1, 2'b10, 0, 4, 0, 0, 0, 4, 1, 4'b0100, 2'b01, 0};
        vecs[5]  = '{1, 0, 2'b00, 3, 0, 0, 0, 0, 3, 1, 4'b0011, 2'b00, 0};
        vecs[6]  = '{1, 0, 2'b00, 0, 9, 9, 1, 1, 0, 0, 4'b0000, 2'b00, 1};
        vecs[7]  = '{0, 0, 2'b00, 0, 9, 9, 1, 1, 0, 0, 4'b0000, 2'b00, 0};
        vecs[8]  = '{1, 0, 2'b10, 0, 9, 9, 1, 1, 0, 0, 4'b0100, 2'b00, 0};
        vecs[9]  = '{1, 1, 2'b10, 0, 6, 6, 1, 0, 6, 1, 4'b0100, 2'b10, 0};
        vecs[10] = '{1, 1, 2'b10, 0, 6, 6, 1, 1, 0, 0, 4'b0100, 2'b00, 1};
        vecs[11] = '{1, 0, 2'b00, 5, 0, 5, 0, 0, 0, 0, 4'b0000, 2'b00, 0};
        vecs[12] = '{1, 1, 2'b00, 2, 2, 2, 1, 0, 9, 1, 4'b1010, 2'b10, 0};

        do_reset();
        chk("reset_stall", {31'd0, stall3}, 0);
        chk("reset_busy", {31'd0, busy3}, 0);

        // vector table: combinational checks, inputs removed before the next edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ex_valid = vecs[i].valid; store = vecs[i].store; alt = vecs[i].alt;
            ex_rs = {vecs[i].rs2, vecs[i].rs1};
            mem_rd = vecs[i].mem_rd; mem_wen = vecs[i].mem_wen; mem_ld = vecs[i].mem_ld;
            wb_rd = vecs[i].wb_rd; wb_wen = vecs[i].wb_wen;
            #1;
            chk($sformatf("vec%0d_fw", i), {28'd0, fw3}, {28'd0, vecs[i].exp_fw});
            chk($sformatf("vec%0d_st", i), {30'd0, st3}, {30'd0, vecs[i].exp_st});
            chk($sformatf("vec%0d_stall", i), {31'd0, stall3}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("vec%0d_stall1", i), {31'd0, stall1}, {31'd0, vecs[i].exp_stall});
            #1 idle();
        end

        // load-use stall length: LD_LAT=3 vs LD_LAT=1
        @(negedge clk);
        ex_valid = 1; ex_rs = {5'd9, 5'd0}; mem_rd = 9; mem_wen = 1; mem_ld = 1;
        #1;
        chk("ld_c0_stall3", {31'd0, stall3}, 1);
        chk("ld_c0_stall1", {31'd0, stall1}, 1);
        next_cycle();
        mem_wen = 0; mem_ld = 0; mem_rd = 0; wb_rd = 9; wb_wen = 1;
        @(negedge clk);
        chk("ld_c1_stall3", {31'd0, stall3}, 1);
        chk("ld_c1_stall1", {31'd0, stall1}, 0);
        chk("ld_c1_fw_wb", {28'd0, fw3}, 4'b1100);
        next_cycle();
        wb_wen = 0;
        @(negedge clk);
        chk("ld_c2_stall3", {31'd0, stall3}, 1);
        next_cycle();
        @(negedge clk);
        chk("ld_c3_stall3", {31'd0, stall3}, 0);
        idle();

        // scoreboard stall until completion
        next_cycle();
        issue = 1; issue_rd = 12;
        next_cycle();
        issue = 0; ex_valid = 1; ex_rs = {5'd0, 5'd12};
        @(negedge clk);
        chk("sb_busy_set", {31'd0, busy3}, 1);
        chk("sb_stall_a", {31'd0, stall3}, 1);
        next_cycle();
        @(negedge clk);
        chk("sb_stall_b", {31'd0, stall3}, 1);
        next_cycle();
        done = 1; done_rd = 12; wb_rd = 12; wb_wen = 1;
        @(negedge clk);
        chk("sb_done_nostall", {31'd0, stall3}, 0);
        chk("sb_done_fw", {28'd0, fw3}, 4'b0011);
        next_cycle();
        done = 0; wb_wen = 0;
        @(negedge clk);
        chk("sb_busy_clr", {31'd0, busy3}, 0);
        chk("sb_stall_clr", {31'd0, stall3}, 0);
        next_cycle();
        ex_valid = 0; issue = 1; issue_rd = 12;
        next_cycle();
        done = 1; done_rd = 12;
        next_cycle();
        issue = 0; done = 0;
        @(negedge clk);
        chk("sb_set_wins", {31'd0, busy3}, 1);
        next_cycle();
        done = 1; done_rd = 12;
        next_cycle();
        done = 0; issue = 1; issue_rd = 0;
        next_cycle();
        issue = 0;
        @(negedge clk);
        chk("sb_x0_ignored", {31'd0, busy3}, 0);

        // async reset mid-LDSTALL and mid-pending
        @(negedge clk);
        ex_valid = 1; ex_rs = {5'd9, 5'd0}; mem_rd = 9; mem_wen = 1; mem_ld = 1;
        issue = 1; issue_rd = 12;
        next_cycle();
        idle();
        @(negedge clk);
        chk("rst_pre_stall", {31'd0, stall3}, 1);
        chk("rst_pre_busy", {31'd0, busy3}, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_stall", {31'd0, stall3}, 0);
        chk("rst_busy3", {31'd0, busy3}, 0);
        chk("rst_busy1", {31'd0, busy1}, 0);
        #1 rst_n = 1;

        // flush mid-LDSTALL
        @(negedge clk);
        ex_valid = 1; ex_rs = {5'd9, 5'd0}; mem_rd = 9; mem_wen = 1; mem_ld = 1;
        next_cycle();
        idle();
        flush = 1;
        @(negedge clk);
        chk("flush_pre", {31'd0, stall3}, 1);
        next_cycle();
        flush = 0;
        @(negedge clk);
        chk("flush_idle", {31'd0, stall3}, 0);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit lh, sh;
            ex_valid = ($urandom_range(0, 7) != 0);
            ex_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            alt      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            store    = ($urandom_range(0, 3) == 0);
            mem_rd   = 5'($urandom_range(0, 7));
            mem_wen  = 1'($urandom_range(0, 1));
            mem_ld   = ($urandom_range(0, 2) == 0);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_wen   = 1'($urandom_range(0, 1));
            issue    = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            done     = ($urandom_range(0, 3) == 0);
            done_rd  = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            lh = m_load_haz();
            sh = m_sb_haz();
            chk("rnd_fw", {28'd0, fw3}, {28'd0, m_fw(1), m_fw(0)});
            chk("rnd_st", {30'd0, st3}, {30'd0, m_st()});
            chk("rnd_stall3", {31'd0, stall3}, {31'd0, (rem3 > 0) || lh || sh});
            chk("rnd_stall1", {31'd0, stall1}, {31'd0, (rem1 > 0) || lh || sh});
            chk("rnd_busy3", {31'd0, busy3}, {31'd0, (mpend != 0)});
            chk("rnd_busy1", {31'd0, busy1}, {31'd0, (mpend != 0)});
            @(posedge clk);
            model_edge(lh);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
